// File: rtl/otbn_pkg.sv
// rtl/otbn_pkg.sv - OTBN granule constants and wide register file wipe FSM encoding
package otbn_pkg;

  localparam int BaseIntgWidth    = 39;
  localparam int BaseWordsPerWLEN = 8;

  typedef enum logic [1:0] {
    RfWipeIdle = 2'd0,
    RfWipeWipe = 2'd1,
    RfWipeDone = 2'd2
  } rf_wipe_state_e;

  localparam logic [1:0] StIdle = RfWipeIdle;
  localparam logic [1:0] StWipe = RfWipeWipe;
  localparam logic [1:0] StDone = RfWipeDone;

endpackage

// File: rtl/otbn_rf_wide_fpga_col.sv
// rtl/otbn_rf_wide_fpga_col.sv - one granule column, 2 write / 2 async read ports, RAM-inferable
module otbn_rf_wide_fpga_col #(
  parameter int               Depth   = 32,
  parameter int               Width   = 39,
  parameter logic [Width-1:0] InitVal = '0,
  localparam int              Aw      = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_a_i,
  input  logic [Aw-1:0]    waddr_a_i,
  input  logic [Width-1:0] wdata_a_i,
  input  logic             we_b_i,
  input  logic [Aw-1:0]    waddr_b_i,
  input  logic [Width-1:0] wdata_b_i,
  input  logic [Aw-1:0]    raddr_a_i,
  output logic [Width-1:0] rdata_a_o,
  input  logic [Aw-1:0]    raddr_b_i,
  output logic [Width-1:0] rdata_b_o
);

  logic [Width-1:0] mem [Depth];

  initial begin
    for (int i = 0; i < Depth; i++) begin
      mem[i] = InitVal;
    end
  end

  // Port B is applied last so it wins when both ports hit the same row.
  always @(posedge clk_i) begin
    if (we_a_i) mem[waddr_a_i] <= wdata_a_i;
    if (we_b_i) mem[waddr_b_i] <= wdata_b_i;
  end

  assign rdata_a_o = mem[raddr_a_i];
  assign rdata_b_o = mem[raddr_b_i];

endmodule

// File: rtl/otbn_rf_wide_fpga_wipe.sv
// rtl/otbn_rf_wide_fpga_wipe.sv - FPGA wide register file with secure-wipe sequencer and write errors
module otbn_rf_wide_fpga_wipe
  import otbn_pkg::*;
#(
  parameter int                  Depth       = 32,
  parameter int                  NumGranules = BaseWordsPerWLEN,
  parameter int                  GranuleW    = BaseIntgWidth,
  parameter logic [GranuleW-1:0] WordZeroVal = '0,
  parameter bit                  AutoWipe    = 1'b1,
  localparam int                 Aw          = $clog2(Depth),
  localparam int                 W           = NumGranules * GranuleW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [Aw-1:0]          wr_addr_a_i,
  input  logic [NumGranules-1:0] wr_en_a_i,
  input  logic [W-1:0]           wr_data_a_i,
  input  logic [Aw-1:0]          wr_addr_b_i,
  input  logic [NumGranules-1:0] wr_en_b_i,
  input  logic [W-1:0]           wr_data_b_i,
  input  logic [Aw-1:0]          rd_addr_a_i,
  output logic [W-1:0]           rd_data_a_o,
  input  logic [Aw-1:0]          rd_addr_b_i,
  output logic [W-1:0]           rd_data_b_o,
  input  logic                   wipe_req_i,
  output logic                   wipe_busy_o,
  output logic                   wipe_done_o,
  output logic                   we_err_o
);

  logic [1:0]             state_q, state_d;
  logic [Aw-1:0]          cnt_q, cnt_d;
  logic                   we_err_q, we_err_d;
  logic                   done_q, done_d;
  logic                   wiping;
  logic                   last_row;
  logic [NumGranules-1:0] we_a, we_b;
  logic [Aw-1:0]          waddr_a;
  logic [W-1:0]           wdata_a;

  assign wiping   = (state_q == StWipe);
  assign last_row = (cnt_q == Aw'(Depth - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (wipe_req_i) begin
          state_d = StWipe;
          cnt_d   = '0;
        end
      end
      StWipe: begin
        cnt_d = cnt_q + 1'b1;
        if (last_row) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    done_d   = wiping && last_row;
    // While wiping any external write attempt is an error; otherwise only overlapping granules are.
    we_err_d = wiping ? ((|wr_en_a_i) || (|wr_en_b_i))
                      : ((wr_addr_a_i == wr_addr_b_i) && (|(wr_en_a_i & wr_en_b_i)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= AutoWipe ? StWipe : StIdle;
      cnt_q    <= '0;
      we_err_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_err_q <= we_err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    we_a    = wr_en_a_i;
    waddr_a = wr_addr_a_i;
    wdata_a = wr_data_a_i;
    we_b    = wr_en_b_i;
    if (wiping) begin
      we_a    = '1;
      waddr_a = cnt_q;
      wdata_a = {NumGranules{WordZeroVal}};
      we_b    = '0;
    end
  end

  for (genvar g = 0; g < NumGranules; g++) begin : gen_col
    otbn_rf_wide_fpga_col #(
      .Depth   (Depth),
      .Width   (GranuleW),
      .InitVal (WordZeroVal)
    ) u_col (
      .clk_i     (clk_i),
      .we_a_i    (we_a[g]),
      .waddr_a_i (waddr_a),
      .wdata_a_i (wdata_a[g*GranuleW +: GranuleW]),
      .we_b_i    (we_b[g]),
      .waddr_b_i (wr_addr_b_i),
      .wdata_b_i (wr_data_b_i[g*GranuleW +: GranuleW]),
      .raddr_a_i (rd_addr_a_i),
      .rdata_a_o (rd_data_a_o[g*GranuleW +: GranuleW]),
      .raddr_b_i (rd_addr_b_i),
      .rdata_b_o (rd_data_b_o[g*GranuleW +: GranuleW])
    );
  end

`ifdef SIMULATION
  logic [W-1:0] rf [Depth];
  for (genvar i = 0; i < Depth; i++) begin : gen_bd
    logic [W-1:0] word;
    for (genvar g = 0; g < NumGranules; g++) begin : gen_bd_g
      assign word[g*GranuleW +: GranuleW] = gen_col[g].u_col.mem[i];
    end
    assign rf[i] = word;
  end
`endif

  assign wipe_busy_o = wiping;
  assign wipe_done_o = done_q;
  assign we_err_o    = we_err_q;

endmodule

// File: tb/tb_otbn_rf_wide_fpga_wipe.sv
// tb/tb_otbn_rf_wide_fpga_wipe.sv - scoreboard bench for the wide register file with wipe
module tb_otbn_rf_wide_fpga_wipe;

  localparam int Depth = 32;
  localparam int NG    = 8;
  localparam int GW    = 39;
  localparam int Aw    = 5;
  localparam int W     = NG * GW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [Aw-1:0] wr_addr_a_i = '0, wr_addr_b_i = '0, rd_addr_a_i = '0, rd_addr_b_i = '0;
  logic [NG-1:0] wr_en_a_i = '0, wr_en_b_i = '0;
  logic [W-1:0]  wr_data_a_i = '0, wr_data_b_i = '0;
  logic [W-1:0]  rd_data_a_o, rd_data_b_o;
  logic          wipe_req_i = 1'b0;
  logic          wipe_busy_o, wipe_done_o, we_err_o;

  always #5 clk = ~clk;

  otbn_rf_wide_fpga_wipe #(
    .Depth       (Depth),
    .NumGranules (NG),
    .GranuleW    (GW),
    .WordZeroVal ('0),
    .AutoWipe    (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .wr_addr_a_i (wr_addr_a_i),
    .wr_en_a_i   (wr_en_a_i),
    .wr_data_a_i (wr_data_a_i),
    .wr_addr_b_i (wr_addr_b_i),
    .wr_en_b_i   (wr_en_b_i),
    .wr_data_b_i (wr_data_b_i),
    .rd_addr_a_i (rd_addr_a_i),
    .rd_data_a_o (rd_data_a_o),
    .rd_addr_b_i (rd_addr_b_i),
    .rd_data_b_o (rd_data_b_o),
    .wipe_req_i  (wipe_req_i),
    .wipe_busy_o (wipe_busy_o),
    .wipe_done_o (wipe_done_o),
    .we_err_o    (we_err_o)
  );

  typedef struct packed {
    logic         chk;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   act_done_cnt = 0;
  int   exp_done_cnt = 0;

  // Reference model: the register contents plus where a wipe sweep currently stands.
  logic [W-1:0] mem [Depth];
  int           wipe_pos = -1;
  bit           in_done = 1'b0;
  bit           prev_err = 1'b0;
  bit           model_known = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  task automatic cyc(input bit rst, input bit req,
                     input int aa, input logic [NG-1:0] ea, input logic [W-1:0] da,
                     input int ab, input logic [NG-1:0] eb, input logic [W-1:0] db,
                     input int ra, input int rb);
    exp_t e;
    bit   nerr;
    @(posedge clk);
    #1;
    rst_i       = rst;
    wipe_req_i  = req;
    wr_addr_a_i = Aw'(aa);
    wr_en_a_i   = ea;
    wr_data_a_i = da;
    wr_addr_b_i = Aw'(ab);
    wr_en_b_i   = eb;
    wr_data_b_i = db;
    rd_addr_a_i = Aw'(ra);
    rd_addr_b_i = Aw'(rb);
    e.chk  = model_known;
    e.busy = (wipe_pos >= 0);
    e.done = in_done;
    e.err  = prev_err;
    e.ra   = mem[ra];
    e.rb   = mem[rb];
    if (e.chk && e.done) exp_done_cnt++;
    q.push_back(e);
    // Advance the model to what the next clock edge produces.
    if (rst) begin
      if (wipe_pos >= 0) mem[wipe_pos] = '0;
      wipe_pos    = 0;
      in_done     = 1'b0;
      prev_err    = 1'b0;
      model_known = 1'b1;
    end else if (wipe_pos >= 0) begin
      mem[wipe_pos] = '0;
      nerr = (ea != 0) || (eb != 0);
      if (wipe_pos == Depth - 1) begin
        wipe_pos = -1;
        in_done  = 1'b1;
      end else begin
        wipe_pos++;
      end
      prev_err = nerr;
    end else begin
      for (int g = 0; g < NG; g++) if (ea[g]) mem[aa][g*GW +: GW] = da[g*GW +: GW];
      for (int g = 0; g < NG; g++) if (eb[g]) mem[ab][g*GW +: GW] = db[g*GW +: GW];
      prev_err = (aa == ab) && ((ea & eb) != 0);
      if (in_done) in_done = 1'b0;
      else if (req) wipe_pos = 0;
    end
  endtask

  task automatic idle(input int n, input bit req);
    for (int i = 0; i < n; i++)
      cyc(1'b0, req, 0, '0, '0, 0, '0, '0, $urandom_range(0, Depth - 1), $urandom_range(0, Depth - 1));
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      if (m.chk) begin
        chk1("wipe_busy", wipe_busy_o, m.busy);
        chk1("wipe_done", wipe_done_o, m.done);
        chk1("we_err", we_err_o, m.err);
        chkw("rd_data_a", rd_data_a_o, m.ra);
        chkw("rd_data_b", rd_data_b_o, m.rb);
        if (wipe_done_o === 1'b1) act_done_cnt++;
      end
    end
  end

  initial begin
    logic [W-1:0] d1, d2;
    int           aa, ab;
    logic [NG-1:0] ea, eb;
    int           wait_n;
    for (int i = 0; i < Depth; i++) mem[i] = '0;

    // Reset, automatic wipe, then idle reads across the array.
    cyc(1'b1, 1'b0, 0, '0, '0, 0, '0, '0, 0, 0);
    cyc(1'b1, 1'b0, 0, '0, '0, 0, '0, '0, 0, 0);
    idle(36, 1'b0);
    for (int i = 0; i < Depth; i++) cyc(1'b0, 1'b0, 0, '0, '0, 0, '0, '0, i, Depth - 1 - i);

    // Full write on A, then partial overwrite of granule 0 on B.
    d1 = rnd_word();
    d2 = rnd_word();
    cyc(1'b0, 1'b0, 5, 8'hFF, d1, 0, '0, '0, 5, 5);
    cyc(1'b0, 1'b0, 0, '0, '0, 5, 8'h01, d2, 5, 5);
    cyc(1'b0, 1'b0, 0, '0, '0, 0, '0, '0, 5, 5);

    // Collision on addr 7: B wins overlapping granules.
    d1 = rnd_word();
    d2 = rnd_word();
    cyc(1'b0, 1'b0, 7, 8'hFF, rnd_word(), 0, '0, '0, 7, 7);
    cyc(1'b0, 1'b0, 7, 8'h0F, d1, 7, 8'h03, d2, 7, 7);
    idle(2, 1'b0);
    cyc(1'b0, 1'b0, 0, '0, '0, 0, '0, '0, 7, 7);

    // Preload addr 3, wipe, attempt a write during the wipe.
    cyc(1'b0, 1'b0, 3, 8'hFF, rnd_word(), 0, '0, '0, 3, 3);
    cyc(1'b0, 1'b1, 0, '0, '0, 0, '0, '0, 3, 3);
    idle(5, 1'b0);
    cyc(1'b0, 1'b0, 3, 8'hFF, rnd_word(), 0, '0, '0, 3, 3);
    idle(30, 1'b0);
    cyc(1'b0, 1'b0, 0, '0, '0, 0, '0, '0, 3, 3);

    // Reset in the middle of a wipe (counter at 10).
    cyc(1'b0, 1'b0, 9, 8'hFF, rnd_word(), 20, 8'hFF, rnd_word(), 9, 20);
    cyc(1'b0, 1'b1, 0, '0, '0, 0, '0, '0, 9, 20);
    idle(10, 1'b0);
    cyc(1'b1, 1'b0, 0, '0, '0, 0, '0, '0, 9, 20);
    idle(40, 1'b0);

    // Request held through DONE: back-to-back wipes with one idle cycle.
    idle(70, 1'b1);
    idle(40, 1'b0);

    // Random traffic with frequent address overlap and occasional wipes.
    for (int i = 0; i < 400; i++) begin
      aa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, Depth - 1);
      ab = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, Depth - 1);
      ea = ($urandom_range(0, 2) == 0) ? '0 : NG'($urandom);
      eb = ($urandom_range(0, 2) == 0) ? '0 : NG'($urandom);
      cyc(1'b0, ($urandom_range(0, 79) == 0), aa, ea, rnd_word(), ab, eb, rnd_word(),
          $urandom_range(0, Depth - 1), ($urandom_range(0, 1) == 0) ? aa : ab);
    end
    idle(40, 1'b0);

    wait_n = 0;
    while (q.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    total++;
    if (act_done_cnt != exp_done_cnt) begin
      bad++;
      $display("FAIL done_count: got %0d expected %0d", act_done_cnt, exp_done_cnt);
    end
`ifdef SIMULATION
    for (int i = 0; i < Depth; i++) chkw("backdoor_rf", dut.rf[i], mem[i]);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
